// File: rtl/date_set_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// date_set_ctrl_pkg
// Shared definitions for the date-edit controller: FSM state encoding,
// field cursor codes, default RTC register addresses and the calendar
// helper that gives the number of days in a month.
// -----------------------------------------------------------------------------
package date_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT     = 3'd1,
    ST_WR_DAY   = 3'd2,
    ST_WR_MONTH = 3'd3,
    ST_WR_YEAR  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Field cursor codes as seen on field_sel.
  localparam logic [1:0] FIELD_DAY   = 2'd0;
  localparam logic [1:0] FIELD_MONTH = 2'd1;
  localparam logic [1:0] FIELD_YEAR  = 2'd2;

  // Default RTC register addresses.
  localparam logic [7:0] ADDR_DAY_DEF   = 8'h24;
  localparam logic [7:0] ADDR_MONTH_DEF = 8'h25;
  localparam logic [7:0] ADDR_YEAR_DEF  = 8'h26;

  // Days in a month for a 2000-based two-digit year. Every year divisible
  // by four in 2000..2099 is a leap year, so no century rule is needed.
  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                input logic [6:0] year);
    logic [4:0] dim;
    case (month)
      4'd2:                      dim = ((year % 7'd4) == 7'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
      default:                   dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/date_set_ctrl_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
// Combinational conversion of a binary value 0..99 to two BCD digits.
// Ports:
//   bin_i  7-bit binary value, expected range 0..99
//   bcd_o  8-bit BCD result {tens, ones}
// Inputs above 99 are never produced by the date fields and give an
// unspecified (truncated) result.
// -----------------------------------------------------------------------------
module bin_to_bcd (
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o
);

  logic [3:0] tens_s;
  logic [3:0] ones_s;

  // Split into decimal digits; division by a constant maps to small logic.
  always_comb begin
    tens_s = 4'(bin_i / 7'd10);
    ones_s = 4'(bin_i % 7'd10);
    bcd_o  = {tens_s, ones_s};
  end

endmodule

// File: rtl/date_set_ctrl.sv
// -----------------------------------------------------------------------------
// date_set_ctrl
// Button-driven date editor that commits day/month/year to an RTC through a
// three-write request/acknowledge sequence.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   EN                            date-edit mode enable
//   btn_up/down/next/save         one-cycle button pulses
//   field_sel                     cursor (0 day, 1 month, 2 year)
//   day_bcd/month_bcd/year_bcd    current date, BCD
//   wr_req/wr_addr/wr_data        RTC write request, address, BCD data
//   wr_ack                        write accepted by RTC bus sequencer
//   busy                          write sequence in progress
//   done                          one-cycle completion pulse
// -----------------------------------------------------------------------------
module date_set_ctrl
  import date_set_ctrl_pkg::*;
#(
  parameter logic [7:0] ADDR_DAY   = ADDR_DAY_DEF,
  parameter logic [7:0] ADDR_MONTH = ADDR_MONTH_DEF,
  parameter logic [7:0] ADDR_YEAR  = ADDR_YEAR_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       EN,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_save,
  output logic [1:0] field_sel,
  output logic [7:0] day_bcd,
  output logic [7:0] month_bcd,
  output logic [7:0] year_bcd,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  logic [4:0] day_q,   day_d;
  logic [3:0] month_q, month_d;
  logic [6:0] year_q,  year_d;
  logic [1:0] sel_q,   sel_d;
  logic       wr_req_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       busy_q;
  logic       done_q;

  logic       inc_s;
  logic       dec_s;
  logic [4:0] max_cur_s;
  logic [4:0] max_new_s;

  logic [7:0] beat_addr_s;
  logic [7:0] beat_data_s;
  state_e     beat_next_s;

  bin_to_bcd u_day_bcd   (.bin_i({2'b00, day_q}),   .bcd_o(day_bcd));
  bin_to_bcd u_month_bcd (.bin_i({3'b000, month_q}), .bcd_o(month_bcd));
  bin_to_bcd u_year_bcd  (.bin_i(year_q),            .bcd_o(year_bcd));

  assign field_sel = sel_q;
  assign wr_req    = wr_req_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next values of the date fields and cursor while editing.
  always_comb begin
    day_d     = day_q;
    month_d   = month_q;
    year_d    = year_q;
    sel_d     = sel_q;
    inc_s     = btn_up & ~btn_down;
    dec_s     = btn_down & ~btn_up;
    max_cur_s = days_in_month(month_q, year_q);
    max_new_s = max_cur_s;
    // Save wins over every other button; leaving EDIT ignores buttons too.
    if ((state_q == ST_EDIT) && EN && !btn_save) begin
      case (sel_q)
        FIELD_DAY: begin
          if (inc_s) begin
            day_d = (day_q >= max_cur_s) ? 5'd1 : day_q + 5'd1;
          end else if (dec_s) begin
            day_d = (day_q <= 5'd1) ? max_cur_s : day_q - 5'd1;
          end else begin
            day_d = day_q;
          end
        end
        FIELD_MONTH: begin
          if (inc_s) begin
            month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
          end else if (dec_s) begin
            month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
          end else begin
            month_d = month_q;
          end
        end
        FIELD_YEAR: begin
          if (inc_s) begin
            year_d = (year_q >= 7'd99) ? 7'd0 : year_q + 7'd1;
          end else if (dec_s) begin
            year_d = (year_q == 7'd0) ? 7'd99 : year_q - 7'd1;
          end else begin
            year_d = year_q;
          end
        end
        default: begin
          sel_d = FIELD_DAY;
        end
      endcase
      // Clamp the day in the same cycle a month/year change shortens the month.
      max_new_s = days_in_month(month_d, year_d);
      day_d     = (day_d > max_new_s) ? max_new_s : day_d;
      // Up/down above used the old cursor; the cursor advances afterwards.
      if (btn_next) begin
        sel_d = (sel_q >= FIELD_YEAR) ? FIELD_DAY : sel_q + 2'd1;
      end else begin
        sel_d = sel_d;
      end
    end else begin
      sel_d = sel_q;
    end
  end

  // Address, data and successor for the write beat of the current state.
  always_comb begin
    case (state_q)
      ST_WR_DAY: begin
        beat_addr_s = ADDR_DAY;
        beat_data_s = day_bcd;
        beat_next_s = ST_WR_MONTH;
      end
      ST_WR_MONTH: begin
        beat_addr_s = ADDR_MONTH;
        beat_data_s = month_bcd;
        beat_next_s = ST_WR_YEAR;
      end
      ST_WR_YEAR: begin
        beat_addr_s = ADDR_YEAR;
        beat_data_s = year_bcd;
        beat_next_s = ST_DONE;
      end
      default: begin
        beat_addr_s = 8'h00;
        beat_data_s = 8'h00;
        beat_next_s = ST_IDLE;
      end
    endcase
  end

  // Control FSM with registered fields and bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      day_q     <= 5'd1;
      month_q   <= 4'd1;
      year_q    <= 7'd0;
      sel_q     <= FIELD_DAY;
      wr_req_q  <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      sel_q   <= sel_d;
      case (state_q)
        ST_IDLE: begin
          state_q <= EN ? ST_EDIT : ST_IDLE;
        end
        ST_EDIT: begin
          if (!EN) begin
            state_q <= ST_IDLE;
          end else if (btn_save) begin
            // The day request is raised on entry to WR_DAY.
            state_q   <= ST_WR_DAY;
            wr_req_q  <= 1'b1;
            wr_addr_q <= ADDR_DAY;
            wr_data_q <= day_bcd;
            busy_q    <= 1'b1;
          end else begin
            state_q <= ST_EDIT;
          end
        end
        ST_WR_DAY, ST_WR_MONTH, ST_WR_YEAR: begin
          if (!wr_req_q) begin
            // Gap cycle after the previous ack; any wr_ack here is ignored.
            wr_req_q  <= 1'b1;
            wr_addr_q <= beat_addr_s;
            wr_data_q <= beat_data_s;
          end else if (wr_ack) begin
            wr_req_q  <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
            state_q   <= beat_next_s;
            if (beat_next_s == ST_DONE) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end else begin
            wr_req_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= EN ? ST_EDIT : ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          wr_req_q  <= 1'b0;
          wr_addr_q <= 8'h00;
          wr_data_q <= 8'h00;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_date_set_ctrl
// Self-checking bench: a table of edit steps with hand-derived expectations,
// a randomized edit phase against a calendar reference model, and directed
// write-sequence / reset corner cases.
// -----------------------------------------------------------------------------
module tb_date_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       EN, btn_up, btn_down, btn_next, btn_save, wr_ack;
  logic [1:0] field_sel;
  logic [7:0] day_bcd, month_bcd, year_bcd, wr_addr, wr_data;
  logic       wr_req, busy, done;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit en, up, dn, nx;
    int d, m, y, s;
  } vec_t;
  vec_t vecs[$];

  // Reference model state (decimal values).
  int m_day, m_mon, m_yr, m_sel;
  bit m_edit;

  always #5 clk = ~clk;

  date_set_ctrl dut (
    .clk(clk), .reset_n(reset_n), .EN(EN),
    .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next), .btn_save(btn_save),
    .field_sel(field_sel), .day_bcd(day_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int dim(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit u, input bit d, input bit n);
    btn_up = u; btn_down = d; btn_next = n;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0;
  endtask

  task automatic chk_date(input string tag, input int d, input int m, input int y);
    chk({tag, "_day"},   int'(day_bcd),   bcd(d));
    chk({tag, "_month"}, int'(month_bcd), bcd(m));
    chk({tag, "_year"},  int'(year_bcd),  bcd(y));
  endtask

  task automatic do_reset();
    EN = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0;
    btn_save = 1'b0; wr_ack = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic addv(input bit en, input bit up, input bit dn, input bit nx,
                      input int d, input int m, input int y, input int s);
    vec_t v;
    v.en = en; v.up = up; v.dn = dn; v.nx = nx;
    v.d = d; v.m = m; v.y = y; v.s = s;
    vecs.push_back(v);
  endtask

  // Calendar model update for one clock edge.
  task automatic model_step(input bit en, input bit u, input bit d, input bit n);
    bit inc, dec;
    int mx;
    inc = u && !d;
    dec = d && !u;
    if (!m_edit) begin
      m_edit = en;
    end else if (!en) begin
      m_edit = 1'b0;
    end else begin
      if (m_sel == 0) begin
        mx = dim(m_mon, m_yr);
        if (inc) m_day = (m_day == mx) ? 1 : m_day + 1;
        if (dec) m_day = (m_day == 1) ? mx : m_day - 1;
      end else if (m_sel == 1) begin
        if (inc) m_mon = m_mon % 12 + 1;
        if (dec) m_mon = (m_mon == 1) ? 12 : m_mon - 1;
      end else begin
        if (inc) m_yr = (m_yr + 1) % 100;
        if (dec) m_yr = (m_yr + 99) % 100;
      end
      if (m_day > dim(m_mon, m_yr)) m_day = dim(m_mon, m_yr);
      if (n) m_sel = (m_sel + 1) % 3;
    end
  endtask

  // One RTC write beat: request held through a delayed ack, then one-cycle gap.
  task automatic write_beat(input string tag, input int a, input int dat,
                            input bit last, input bit gap_ack);
    int waited = 0;
    while (wr_req !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    chk({tag, "_req_latency"}, waited, 0);
    chk({tag, "_busy"}, int'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_req_hold"}, int'(wr_req), 1);
      chk({tag, "_addr"}, int'(wr_addr), a);
      chk({tag, "_data"}, int'(wr_data), dat);
      btn_up = 1'b1; btn_next = 1'b1;
      tick();
      btn_up = 1'b0; btn_next = 1'b0;
    end
    chk({tag, "_addr_end"}, int'(wr_addr), a);
    chk({tag, "_data_end"}, int'(wr_data), dat);
    wr_ack = 1'b1;
    tick();
    chk({tag, "_req_drop"}, int'(wr_req), 0);
    chk({tag, "_addr_idle"}, int'(wr_addr), 0);
    chk({tag, "_data_idle"}, int'(wr_data), 0);
    if (last) begin
      wr_ack = 1'b0;
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_busy_off"}, int'(busy), 0);
      tick();
      chk({tag, "_done_pulse"}, int'(done), 0);
      chk({tag, "_req_after"}, int'(wr_req), 0);
    end else begin
      chk({tag, "_busy_gap"}, int'(busy), 1);
      wr_ack = gap_ack;
      tick();
      wr_ack = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit en, u, d, n;

    // ---------------- Reset state ----------------
    EN = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0;
    btn_save = 1'b0; wr_ack = 1'b0; reset_n = 1'b0;
    tick();
    chk_date("rst", 1, 1, 0);
    chk("rst_sel", int'(field_sel), 0);
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    reset_n = 1'b1;
    tick();
    EN = 1'b1;
    tick();

    // ---------------- Table-driven editing ----------------
    addv(1,1,0,0,  2, 1, 0,0);
    addv(1,1,0,0,  3, 1, 0,0);
    addv(1,1,0,0,  4, 1, 0,0);
    addv(1,1,1,0,  4, 1, 0,0);   // up+down together: no change
    addv(1,0,1,0,  3, 1, 0,0);
    addv(1,0,1,0,  2, 1, 0,0);
    addv(1,0,1,0,  1, 1, 0,0);
    addv(1,0,1,0, 31, 1, 0,0);   // day min wraps to January max
    addv(1,0,0,1, 31, 1, 0,1);
    addv(1,1,0,0, 29, 2, 0,1);   // Feb of year 00 is leap: clamp to 29
    addv(1,0,0,1, 29, 2, 0,2);
    addv(1,1,0,0, 28, 2, 1,2);   // year 01: clamp to 28
    addv(1,0,1,0, 28, 2, 0,2);
    addv(1,0,1,0, 28, 2,99,2);   // year 0 wraps to 99
    addv(1,1,0,0, 28, 2, 0,2);
    addv(1,1,0,1, 28, 2, 1,0);   // up on old field, then cursor wraps
    addv(1,1,0,0,  1, 2, 1,0);
    addv(1,0,1,0, 28, 2, 1,0);
    addv(1,0,0,1, 28, 2, 1,1);
    addv(1,0,1,0, 28, 1, 1,1);
    addv(1,0,1,0, 28,12, 1,1);
    addv(1,1,0,0, 28, 1, 1,1);   // month 12 wraps to 1
    addv(1,0,0,1, 28, 1, 1,2);
    addv(1,0,0,1, 28, 1, 1,0);
    addv(0,0,0,0, 28, 1, 1,0);   // leave EDIT, values kept
    addv(0,1,0,1, 28, 1, 1,0);   // IDLE ignores buttons
    addv(1,1,0,0, 28, 1, 1,0);   // IDLE->EDIT, button ignored on that edge
    addv(1,1,0,0, 29, 1, 1,0);
    addv(1,1,0,0, 30, 1, 1,0);
    addv(1,1,0,0, 31, 1, 1,0);
    addv(1,0,0,1, 31, 1, 1,1);
    addv(1,1,0,0, 28, 2, 1,1);   // 31 Jan -> Feb year 01: 28
    addv(1,0,1,0, 28, 1, 1,1);
    addv(1,0,0,1, 28, 1, 1,2);
    addv(1,1,0,0, 28, 1, 2,2);
    addv(1,1,0,0, 28, 1, 3,2);
    addv(1,1,0,0, 28, 1, 4,2);
    addv(1,0,0,1, 28, 1, 4,0);
    addv(1,1,0,0, 29, 1, 4,0);
    addv(1,1,0,0, 30, 1, 4,0);
    addv(1,1,0,0, 31, 1, 4,0);
    addv(1,0,0,1, 31, 1, 4,1);
    addv(1,1,0,0, 29, 2, 4,1);   // 31 Jan -> Feb year 04: 29
    foreach (vecs[i]) begin
      EN = vecs[i].en;
      press(vecs[i].up, vecs[i].dn, vecs[i].nx);
      chk_date($sformatf("tbl%0d", i), vecs[i].d, vecs[i].m, vecs[i].y);
      chk($sformatf("tbl%0d_sel", i), int'(field_sel), vecs[i].s);
    end

    // ---------------- Randomized editing vs. calendar model ----------------
    do_reset();
    m_day = 1; m_mon = 1; m_yr = 0; m_sel = 0; m_edit = 1'b0;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 19) != 0);
      u  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      n  = ($urandom_range(0, 3) == 0);
      EN = en;
      press(u, d, n);
      model_step(en, u, d, n);
      chk_date("rnd", m_day, m_mon, m_yr);
      chk("rnd_sel", int'(field_sel), m_sel);
    end

    // ---------------- Write sequence 15/08/24, EN kept high ----------------
    do_reset();
    EN = 1'b1;
    tick();
    repeat (14) press(1, 0, 0);
    press(0, 0, 1);
    repeat (7) press(1, 0, 0);
    press(0, 0, 1);
    repeat (24) press(1, 0, 0);
    chk_date("preset", 15, 8, 24);
    btn_save = 1'b1; btn_up = 1'b1; btn_next = 1'b1;
    tick();
    btn_save = 1'b0; btn_up = 1'b0; btn_next = 1'b0;
    chk_date("save_prio", 15, 8, 24);
    chk("save_sel", int'(field_sel), 2);
    write_beat("wA_day",   8'h24, 8'h15, 1'b0, 1'b1);  // ack held over gap
    write_beat("wA_month", 8'h25, 8'h08, 1'b0, 1'b0);
    write_beat("wA_year",  8'h26, 8'h24, 1'b1, 1'b0);
    chk_date("wA_after", 15, 8, 24);
    press(1, 0, 0);                                    // back in EDIT, cursor on year
    chk_date("wA_edit", 15, 8, 25);
    press(0, 1, 0);
    chk_date("wA_edit2", 15, 8, 24);

    // ---------------- Write sequence, EN drops mid-way ----------------
    btn_save = 1'b1;
    tick();
    btn_save = 1'b0;
    write_beat("wB_day",   8'h24, 8'h15, 1'b0, 1'b0);
    EN = 1'b0;
    write_beat("wB_month", 8'h25, 8'h08, 1'b0, 1'b0);
    write_beat("wB_year",  8'h26, 8'h24, 1'b1, 1'b0);
    EN = 1'b1;
    press(1, 0, 0);                                    // IDLE->EDIT: up ignored
    chk_date("wB_idle", 15, 8, 24);
    chk("wB_busy", int'(busy), 0);

    // ---------------- Reset during WR_MONTH ----------------
    btn_save = 1'b1;
    tick();
    btn_save = 1'b0;
    write_beat("wC_day", 8'h24, 8'h15, 1'b0, 1'b0);
    chk("wC_month_req", int'(wr_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("wC_async_req", int'(wr_req), 0);
    chk("wC_async_busy", int'(busy), 0);
    chk("wC_async_addr", int'(wr_addr), 0);
    chk("wC_async_data", int'(wr_data), 0);
    chk_date("wC_async", 1, 1, 0);
    chk("wC_async_sel", int'(field_sel), 0);
    tick();
    reset_n = 1'b1;
    wr_ack = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (wr_req === 1'b1) cnt++;
    end
    wr_ack = 1'b0;
    chk("wC_no_writes", cnt, 0);
    chk_date("wC_final", 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
